usbh_report_uart_hex: RTL and testbench

//  Downstream consumer of usbh_host_hid: captures each HID report (hid_report/hid_valid)
//  and streams it as uppercase ASCII hex over an 8N1 UART TX (to ftdi_rxd), one line per

---
 rtl/usbh_report_uart_hex.sv | 105 ++++++++++
 tb/tb_usbh_report_uart_hex.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/usbh_report_uart_hex.sv
// usbh_report_uart_hex: streams each HID report as uppercase ASCII hex plus CR LF over an 8N1 UART.
module usbh_report_uart_hex #(
  parameter int C_report_length = 20,
  parameter int C_clk_freq      = 6000000,
  parameter int C_baud          = 115200,
  parameter int C_only_changes  = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [8*C_report_length-1:0] hid_report,
  input  logic                         hid_valid,
  output logic                         uart_txd,
  output logic                         busy,
  output logic [7:0]                   dropped
);
  localparam int N   = C_report_length;
  localparam int DIV = C_clk_freq / C_baud;
  localparam int BW  = $clog2(DIV);
  localparam int IW  = $clog2(2 * N + 2);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t          state_q, state_d;
  logic [8*N-1:0]  last_q, last_d;
  logic            first_q, first_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;
  logic [9:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [7:0]      dropped_q, dropped_d;
  logic [7:0]      byt, char;
  logic [3:0]      nib;
  logic            accept;
  // The last-sent register doubles as the shadow copy being transmitted.
  always_comb begin
    byt     = 8'(last_q >> {idx_q[IW-1:1], 3'b000});
    nib     = idx_q[0] ? byt[3:0] : byt[7:4];
    char    = idx_q == IW'(2 * N) ? 8'h0D :
              idx_q == IW'(2 * N + 1) ? 8'h0A :
              nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    accept  = hid_valid && state_q == IDLE &&
              (first_q || C_only_changes == 0 || hid_report != last_q);
    state_d = state_q;
    last_d  = last_q;
    first_d = first_q;
    idx_d   = idx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (accept) begin
        last_d  = hid_report;
        first_d = 1'b0;
        idx_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = {1'b1, char, 1'b0};
        baud_d  = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        baud_d = baud_q + 1'b1;
        if (baud_q == BW'(DIV - 1)) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'd9) begin
            state_d = idx_q == IW'(2 * N + 1) ? IDLE : LOAD;
            idx_d   = idx_q == IW'(2 * N + 1) ? idx_q : idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    txd_d     = state_q == SHIFT ? shift_q[0] : 1'b1;
    dropped_d = hid_valid && state_q != IDLE && dropped_q != 8'hFF ? dropped_q + 8'd1 : dropped_q;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_q    <= '0;
      first_q   <= 1'b1;
      idx_q     <= '0;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '1;
      txd_q     <= 1'b1;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      first_q   <= first_d;
      idx_q     <= idx_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      dropped_q <= dropped_d;
    end
  end
  assign uart_txd = txd_q;
  assign busy     = state_q != IDLE;
  assign dropped  = dropped_q;
endmodule

// File: tb/tb_usbh_report_uart_hex.sv
// tb_usbh_report_uart_hex: directed checks of hex line framing, change filter, drop counter and async reset.
module tb_usbh_report_uart_hex;
  logic        clk = 0, resetn = 1, hv = 0, hv0 = 0;
  logic [15:0] rep = 0;
  logic        txd, busy, txd0, busy0;
  logic [7:0]  dropped, dropped0;
  int          checks = 0, errors = 0;

  usbh_report_uart_hex #(.C_report_length(2), .C_clk_freq(8), .C_baud(1), .C_only_changes(1)) dut (
    .clk(clk), .resetn(resetn), .hid_report(rep), .hid_valid(hv),
    .uart_txd(txd), .busy(busy), .dropped(dropped));
  usbh_report_uart_hex #(.C_report_length(2), .C_clk_freq(8), .C_baud(1), .C_only_changes(0)) dut0 (
    .clk(clk), .resetn(resetn), .hid_report(rep), .hid_valid(hv0),
    .uart_txd(txd0), .busy(busy0), .dropped(dropped0));

  always #5 clk = ~clk;

  task automatic strobe(input logic [15:0] r, input bit w);
    @(negedge clk);
    rep = r;
    if (w) hv0 = 1; else hv = 1;
    @(negedge clk);
    hv = 0;
    hv0 = 0;
  endtask

  task automatic rx_char(input bit w, output logic [7:0] c, output bit ok);
    logic s [80];
    int   t = 0;
    ok = 1;
    c  = 'x;
    while ((w ? txd0 : txd) === 1'b1 && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) begin
      ok = 0;
      return;
    end
    for (int j = 0; j < 80; j++) begin
      s[j] = w ? txd0 : txd;
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 1; j < 8; j++) if (s[8*k+j] !== s[8*k]) ok = 0;
      if (k >= 1 && k <= 8) c[k-1] = s[8*k];
    end
    if (s[0] !== 1'b0 || s[72] !== 1'b1) ok = 0;
  endtask

  task automatic check_line(input bit w, input logic [47:0] exp, input string nm);
    logic [7:0] c;
    bit         ok;
    for (int i = 0; i < 6; i++) begin
      rx_char(w, c, ok);
      checks++;
      if (!ok || c !== exp[47-8*i -: 8]) begin
        errors++;
        $display("FAIL %s char%0d: got %h (framing ok=%0d), expected %h", nm, i, c, ok, exp[47-8*i -: 8]);
      end
    end
  endtask

  task automatic test_reset;
    #1 resetn = 0;
    #2;
    checks += 4;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped); end
    if (txd0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL reset_dut0: txd %b busy %b expected 1 0", txd0, busy0); end
    @(negedge clk);
    resetn = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_zero;
    strobe(16'h0000, 0);
    check_line(0, {"0000", 8'h0D, 8'h0A}, "first_zero");
  endtask

  task automatic test_basic;
    int lat = 0, bc = 0;
    strobe(16'h3AF1, 0);
    fork
      begin
        while (txd === 1'b1 && lat < 20) begin lat++; @(negedge clk); end
        checks++;
        if (lat != 2) begin errors++; $display("FAIL start_latency: got %0d expected 2", lat); end
        check_line(0, {"F13A", 8'h0D, 8'h0A}, "basic");
      end
      begin
        while (busy === 1'b1 && bc < 2000) begin bc++; @(negedge clk); end
        checks++;
        if (bc != 486) begin errors++; $display("FAIL busy_len: got %0d expected 486", bc); end
      end
    join
  endtask

  task automatic test_change_filter;
    bit bad = 0;
    strobe(16'h3AF1, 0);
    for (int i = 0; i < 200; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad = 1;
      @(negedge clk);
    end
    checks += 2;
    if (bad) begin errors++; $display("FAIL repeat_suppressed: activity seen, expected none"); end
    if (dropped !== 8'd0) begin errors++; $display("FAIL repeat_dropped: got %0d expected 0", dropped); end
    strobe(16'h3AF2, 0);
    check_line(0, {"F23A", 8'h0D, 8'h0A}, "changed");
  endtask

  task automatic test_send_all;
    strobe(16'h3AF1, 1);
    check_line(1, {"F13A", 8'h0D, 8'h0A}, "all_first");
    strobe(16'h3AF1, 1);
    check_line(1, {"F13A", 8'h0D, 8'h0A}, "all_repeat");
  endtask

  task automatic test_back_to_back;
    strobe(16'h1234, 0);
    fork
      check_line(0, {"3412", 8'h0D, 8'h0A}, "during_drops");
      begin
        for (int i = 0; i < 300; i++) begin
          rep = 16'($urandom);
          hv = 1;
          @(negedge clk);
        end
        hv = 0;
      end
    join
    checks++;
    if (dropped !== 8'd255) begin errors++; $display("FAIL dropped_sat: got %0d expected 255", dropped); end
  endtask

  task automatic test_async_reset;
    strobe(16'h3AF1, 0);
    repeat (164) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL char3_start: got %b expected 0", txd); end
    #1 resetn = 0;
    #1;
    checks += 3;
    if (txd !== 1'b1) begin errors++; $display("FAIL async_txd: got %b expected 1", txd); end
    if (busy !== 1'b0) begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
    if (dropped !== 8'd0) begin errors++; $display("FAIL async_dropped: got %0d expected 0", dropped); end
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    strobe(16'h3AF1, 0);
    check_line(0, {"F13A", 8'h0D, 8'h0A}, "after_reset");
  endtask

  initial begin
    test_reset;
    test_first_zero;
    test_basic;
    test_change_filter;
    test_send_all;
    test_back_to_back;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
